// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared types and constants for the CPU core and its fetch unit.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 8;
    localparam int BYTE_W  = 8;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        FETCH_HI = 2'd0,
        FETCH_LO = 2'd1,
        DRAIN    = 2'd2
    } fetch_state_t;

    // One buffered instruction together with the address of its high byte
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Opcode field (instr[15:12]) values decoded by the core
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_LD   = 4'h4;
    localparam logic [3:0] OP_ST   = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

endpackage
`default_nettype wire

// File: rtl/instr_fifo.sv
`default_nettype none
// ============================================================================
// Module   : instr_fifo
// Brief    : Small power-of-two FIFO of {pc, instr} entries with flush.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  fetch_entry_t             i_push_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output fetch_entry_t             o_head,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t       r_mem [DEPTH];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [PW:0]        r_count;

    // Storage write; a flush in the same cycle wins over the push
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^PW
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : Fetches 16-bit big-endian instructions from byte memory into a
//            FIFO feeding the core; supports redirect flush and halt.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [7:0]  RESET_PC = 8'h00
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic [BYTE_W-1:0]        imem_rdata,
    input  logic                     imem_ready,
    output logic                     instr_valid,
    output logic [INSTR_W-1:0]       instr,
    output logic [ADDR_W-1:0]        instr_pc,
    input  logic                     instr_ready,
    input  logic                     redirect_valid,
    input  logic [ADDR_W-1:0]        redirect_pc,
    input  logic                     halt,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] C_DEPTH = (CW+1)'(DEPTH);

    fetch_state_t       r_state;
    fetch_state_t       w_state_nxt;
    logic               r_req;
    logic               w_req_nxt;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [ADDR_W-1:0]  w_fetch_pc_nxt;
    logic [BYTE_W-1:0]  r_hi;
    logic [BYTE_W-1:0]  w_hi_nxt;

    logic               w_xfer;
    logic               w_push;
    logic               w_pop;
    logic               w_valid;
    logic [CW-1:0]      w_count;
    logic [CW:0]        w_occ;
    logic               w_can_start;
    fetch_entry_t       w_push_data;
    fetch_entry_t       w_head;

    assign w_xfer      = r_req & imem_ready;
    assign w_push      = (r_state == FETCH_LO) & w_xfer & ~redirect_valid;
    assign w_pop       = instr_ready & w_valid;
    assign w_push_data = {r_fetch_pc, r_hi, imem_rdata};

    // Slot reservation: the entry being pushed now counts as occupied and a
    // same-cycle pop is not yet treated as freeing a slot
    assign w_occ       = {1'b0, w_count} + {{CW{1'b0}}, w_push};
    assign w_can_start = ~halt & (w_occ < C_DEPTH);

    // State and memory-interface registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= FETCH_HI;
            r_req      <= 1'b0;
            r_addr     <= '0;
            r_fetch_pc <= RESET_PC;
            r_hi       <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_req      <= w_req_nxt;
            r_addr     <= w_addr_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_hi       <= w_hi_nxt;
        end
    end

    // Next-state and next request; redirect has priority over everything
    always_comb begin
        w_state_nxt    = r_state;
        w_req_nxt      = r_req;
        w_addr_nxt     = r_addr;
        w_fetch_pc_nxt = r_fetch_pc;
        w_hi_nxt       = r_hi;
        if (redirect_valid) begin
            w_fetch_pc_nxt = redirect_pc & 8'hFE;
            w_hi_nxt       = '0;
            if (r_req && !imem_ready) begin
                // Request must stay up until memory accepts it
                w_state_nxt = DRAIN;
            end else begin
                w_state_nxt = FETCH_HI;
                w_req_nxt   = 1'b0;
            end
        end else begin
            case (r_state)
                FETCH_HI: begin
                    if (r_req) begin
                        if (imem_ready) begin
                            w_hi_nxt    = imem_rdata;
                            w_state_nxt = FETCH_LO;
                            w_addr_nxt  = r_fetch_pc + 8'd1;
                        end
                    end else if (w_can_start) begin
                        w_req_nxt  = 1'b1;
                        w_addr_nxt = r_fetch_pc;
                    end
                end
                FETCH_LO: begin
                    if (w_xfer) begin
                        w_fetch_pc_nxt = r_fetch_pc + 8'd2;
                        w_state_nxt    = FETCH_HI;
                        // Back-to-back hi fetch keeps one instruction per 2 cycles
                        w_req_nxt      = w_can_start;
                        if (w_can_start) begin
                            w_addr_nxt = r_fetch_pc + 8'd2;
                        end
                    end
                end
                DRAIN: begin
                    if (w_xfer) begin
                        w_state_nxt = FETCH_HI;
                        w_req_nxt   = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = FETCH_HI;
                    w_req_nxt   = 1'b0;
                end
            endcase
        end
    end

    instr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid),
        .o_head      (w_head),
        .o_valid     (w_valid),
        .o_count     (w_count)
    );

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign instr_valid = w_valid;
    assign instr       = w_head.instr;
    assign instr_pc    = w_head.pc;
    assign fifo_count  = w_count;

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of the multi-cycle CPU core.
- Fetches 16-bit instructions as two big-endian bytes from an 8-bit byte-addressed instruction memory.
- Buffers fetched instructions in a small FIFO and presents them on the core's instr_valid/instr/instr_ready handshake.
- Supports PC redirect (branch/jump flush) and a halt input that stops fetching.

Parameters:
- DEPTH, 4, FIFO entries (power of two, 2..16).
- RESET_PC, 8'h00, first fetch byte address after reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  memory read request; held until accepted.
- imem_addr  out  8  byte address; stable while imem_req=1.
- imem_rdata  in  8  read data; valid in the cycle imem_ready=1.
- imem_ready  in  1  request accepted and data returned this cycle.
- instr_valid  out  1  FIFO head valid.
- instr  out  16  FIFO head instruction, {byte@addr, byte@addr+1}.
- instr_pc  out  8  byte address of the head instruction's high byte.
- instr_ready  in  1  core accepts the head this cycle.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  8  new fetch address; bit 0 ignored (forced 0).
- halt  in  1  level; no new instruction fetch begins while high.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async, rst=1):
  - state=FETCH_HI, fetch_pc=RESET_PC, FIFO empty.
  - imem_req=0, imem_addr=0, instr_valid=0, fifo_count=0.
  - instr and instr_pc are don't-care while instr_valid=0.
- Reset mid-transfer: any outstanding memory request is abandoned; memory must tolerate a dropped imem_req.
- Memory handshake:
  - imem_req and imem_addr are registered.
  - A transfer completes on a clk edge where imem_req=1 and imem_ready=1; data is sampled that edge.
  - imem_req drops or advances address the cycle after completion.
- States:
  - FETCH_HI: if (count+pending)<DEPTH and !halt, assert req at fetch_pc; on completion latch hi byte, go to FETCH_LO. Otherwise req=0 and wait.
  - FETCH_LO: req at fetch_pc+1; on completion push {hi, rdata} with pc=fetch_pc, fetch_pc+=2, go to FETCH_HI.
  - DRAIN: entered on redirect while a request is outstanding; hold req until completion, discard data, go to FETCH_HI at the saved redirect address.
- Redirect:
  - Flushes the FIFO in the same edge (count=0 next cycle).
  - Discards any latched hi byte and loads fetch_pc=redirect_pc&8'hFE.
  - If imem_req=1 and imem_ready=0, go to DRAIN. If imem_ready=1 the same edge, the transfer completes and its data is discarded.
  - Redirect beats a simultaneous push and pop; a head consumed in that cycle counts as delivered.
- FIFO:
  - Head registered; instr_valid = (count!=0).
  - Push and pop in the same cycle leaves count unchanged.
  - A pop on empty is impossible by protocol.
  - No push can occur when full, because FETCH_HI reserves a slot.
  - A hi fetch starts only if count<DEPTH, counting a pop in the same cycle as not yet freed.
- Address arithmetic: 8-bit wrap; fetch_pc=8'hFE fetches FE,FF and then continues at 00.
- halt: a fetch already in FETCH_LO completes; the FIFO still drains to the core; fetching resumes when halt falls.
- Latency and throughput:
  - Always-ready memory: first imem_req the cycle after rst falls; instr_valid 3 cycles after rst falls.
  - Sustained throughput is 1 instruction per 2 cycles.

Decomposition:
- Shared package (cpu_pkg):
  - fetch state encoding (FETCH_HI, FETCH_LO, DRAIN);
  - INSTR_W=16, ADDR_W=8, BYTE_W=8;
  - the opcode constants already used by the core.
- One natural sub-module: instr_fifo (DEPTH x {pc[7:0], instr[15:0]}), with push, pop, flush and count.

Test Plan:
- Reset release, always-ready memory with bytes 00:12,01:34,02:56,03:78 -> instr_valid in cycle 3, instr=16'h1234 pc=00, then 16'h5678 pc=02.
- instr_ready=0 held -> exactly DEPTH=4 entries; imem_req stays 0 while full; one pop -> next fetch starts at 08.
- imem_ready delayed 3 cycles on the low-byte fetch -> imem_addr stable at 01 with req high throughout; correct instr pushed.
- redirect_valid with redirect_pc=8'h41 while a request is outstanding (imem_ready low) -> DRAIN, data discarded, FIFO empty next cycle; the following fetch is at 40/41; no stale instruction delivered.
- fetch_pc=8'hFE -> bytes FE,FF form instr with pc=FE; the next fetch address is 00.
- halt asserted during FETCH_LO -> that instruction is pushed; no further req until halt=0; buffered entries still delivered.
